// File: rtl/ex_pkg.sv
// Shared opcode constants for the execute stage and its iterative mul/div unit.
package ex_pkg;

    localparam logic [2:0] ALUOP_ADD  = 3'b000;
    localparam logic [2:0] ALUOP_SUB  = 3'b001;
    localparam logic [2:0] ALUOP_AND  = 3'b010;
    localparam logic [2:0] ALUOP_OR   = 3'b011;
    localparam logic [2:0] ALUOP_XOR  = 3'b100;
    localparam logic [2:0] ALUOP_NOR  = 3'b101;
    localparam logic [2:0] ALUOP_SLT  = 3'b110;
    localparam logic [2:0] ALUOP_SLTU = 3'b111;

    localparam logic [1:0] SHOP_SLL  = 2'b00;
    localparam logic [1:0] SHOP_SRL  = 2'b01;
    localparam logic [1:0] SHOP_SRA  = 2'b10;
    localparam logic [1:0] SHOP_PASS = 2'b11;

    localparam logic [2:0] MDOP_NONE  = 3'b000;
    localparam logic [2:0] MDOP_MULT  = 3'b001;
    localparam logic [2:0] MDOP_MULTU = 3'b010;
    localparam logic [2:0] MDOP_DIV   = 3'b011;
    localparam logic [2:0] MDOP_DIVU  = 3'b100;
    localparam logic [2:0] MDOP_MFHI  = 3'b101;
    localparam logic [2:0] MDOP_MFLO  = 3'b110;

    // Unit opcode: bit1 = divide, bit0 = unsigned.
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    function automatic logic md_is_start(input logic [2:0] mdop);
        return (mdop == MDOP_MULT) || (mdop == MDOP_MULTU) ||
               (mdop == MDOP_DIV)  || (mdop == MDOP_DIVU);
    endfunction

    function automatic logic md_is_use(input logic [2:0] mdop);
        return (mdop != MDOP_NONE) && (mdop != 3'b111);
    endfunction

    function automatic logic [1:0] md_code(input logic [2:0] mdop);
        case (mdop)
            MDOP_MULTU: md_code = MD_MULTU;
            MDOP_DIV:   md_code = MD_DIV;
            MDOP_DIVU:  md_code = MD_DIVU;
            default:    md_code = MD_MULT;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Radix-2 shift-add multiply / restoring divide on magnitudes, sign fixed on the last step.
// XLEN cycles per op after the start edge; busy while iterating, start ignored by caller when busy.
module muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0]   ONE  = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [2*XLEN-1:0] ONE2 = {{(2*XLEN-1){1'b0}}, 1'b1};

    logic [CW-1:0]   count;
    logic [XLEN-1:0] acc, qr, opb;
    logic            is_div, neg_main, neg_rem;

    logic            sa, sb;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN:0]   mul_sum, div_sh;
    logic            div_ge;
    logic [XLEN-1:0] div_rem, nxt_hi, nxt_lo, fin_hi, fin_lo;
    logic [2*XLEN-1:0] prod, prod_neg;

    always_comb begin
        sa    = ~op[0] & a[XLEN-1];
        sb    = ~op[0] & b[XLEN-1];
        mag_a = sa ? (~a + ONE) : a;
        mag_b = sb ? (~b + ONE) : b;

        mul_sum = {1'b0, acc} + (qr[0] ? {1'b0, opb} : '0);
        div_sh  = {acc, qr[XLEN-1]};
        div_ge  = div_sh >= {1'b0, opb};
        div_rem = div_ge ? (div_sh[XLEN-1:0] - opb) : div_sh[XLEN-1:0];

        if (is_div) begin
            nxt_hi = div_rem;
            nxt_lo = {qr[XLEN-2:0], div_ge};
        end else begin
            nxt_hi = mul_sum[XLEN:1];
            nxt_lo = {mul_sum[0], qr[XLEN-1:1]};
        end

        prod     = {nxt_hi, nxt_lo};
        prod_neg = ~prod + ONE2;
        fin_hi   = nxt_hi;
        fin_lo   = nxt_lo;
        if (count == CW'(1)) begin
            if (is_div) begin
                fin_lo = neg_main ? (~nxt_lo + ONE) : nxt_lo;
                fin_hi = neg_rem  ? (~nxt_hi + ONE) : nxt_hi;
            end else if (neg_main) begin
                {fin_hi, fin_lo} = prod_neg;
            end
        end
    end

    // A zero divisor leaves quotient all ones and remainder = |dividend|; only the remainder sign is restored.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            acc      <= '0;
            qr       <= '0;
            opb      <= '0;
            is_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
        end else if (start) begin
            count    <= CW'(XLEN);
            acc      <= '0;
            qr       <= mag_a;
            opb      <= mag_b;
            is_div   <= op[1];
            neg_main <= op[1] ? ((sa ^ sb) & (b != '0)) : (sa ^ sb);
            neg_rem  <= sa;
        end else if (busy) begin
            count <= count - CW'(1);
            acc   <= fin_hi;
            qr    <= fin_lo;
        end
    end

    assign busy = (count != '0);
    assign hi   = acc;
    assign lo   = qr;

endmodule

// File: rtl/ex_stage_md.sv
// Execute stage: ALU/shifter/HI-LO read registered in 1 cycle, mul/div iterates XLEN cycles.
// Decode is held combinationally only when an md instruction meets a busy unit; flush/stall insert bubbles.
module ex_stage_md
    import ex_pkg::*;
#(
    parameter  int XLEN = 32,
    parameter  int REGW = 5,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            id_ex_valid,
    input  logic [2:0]      id_ex_aluop,
    input  logic            id_ex_unsig,
    input  logic            id_ex_selimregb,
    input  logic            id_ex_selalushift,
    input  logic [1:0]      id_ex_shiftop,
    input  logic [SHW-1:0]  id_ex_shiftamt,
    input  logic [2:0]      id_ex_mdop,
    input  logic [XLEN-1:0] id_ex_rega,
    input  logic [XLEN-1:0] id_ex_regb,
    input  logic [XLEN-1:0] id_ex_imedext,
    input  logic            id_ex_readmem,
    input  logic            id_ex_writemem,
    input  logic            id_ex_selwsource,
    input  logic            id_ex_writereg,
    input  logic            id_ex_writeov,
    input  logic [REGW-1:0] id_ex_regdest,
    output logic            ex_id_stall,
    output logic            ex_if_stall,
    output logic            ex_mem_readmem,
    output logic            ex_mem_writemem,
    output logic            ex_mem_selwsource,
    output logic            ex_mem_writereg,
    output logic [XLEN-1:0] ex_mem_regb,
    output logic [XLEN-1:0] ex_mem_wbvalue,
    output logic [REGW-1:0] ex_mem_regdest,
    output logic            md_busy
);

    logic [XLEN-1:0] alu_b, b_eff, sum, alu_res, sh_res, wb_next, hi, lo;
    logic            is_sub, ov_raw, ov, bubble, md_start;

    always_comb begin
        alu_b   = id_ex_selimregb ? id_ex_imedext : id_ex_regb;
        is_sub  = (id_ex_aluop == ALUOP_SUB);
        b_eff   = is_sub ? ~alu_b : alu_b;
        sum     = id_ex_rega + b_eff + {{(XLEN-1){1'b0}}, is_sub};
        // Operands of equal sign (after inversion for sub) producing a result of the other sign.
        ov_raw  = (id_ex_rega[XLEN-1] == b_eff[XLEN-1]) && (sum[XLEN-1] != id_ex_rega[XLEN-1]);
        ov      = ((id_ex_aluop == ALUOP_ADD) || is_sub) && !id_ex_unsig && ov_raw;

        alu_res = '0;
        case (id_ex_aluop)
            ALUOP_ADD,
            ALUOP_SUB:  alu_res = sum;
            ALUOP_AND:  alu_res = id_ex_rega & alu_b;
            ALUOP_OR:   alu_res = id_ex_rega | alu_b;
            ALUOP_XOR:  alu_res = id_ex_rega ^ alu_b;
            ALUOP_NOR:  alu_res = ~(id_ex_rega | alu_b);
            ALUOP_SLT:  alu_res[0] = $signed(id_ex_rega) < $signed(alu_b);
            ALUOP_SLTU: alu_res[0] = id_ex_rega < alu_b;
            default:    alu_res = sum;
        endcase

        sh_res = id_ex_regb;
        case (id_ex_shiftop)
            SHOP_SLL:  sh_res = id_ex_regb << id_ex_shiftamt;
            SHOP_SRL:  sh_res = id_ex_regb >> id_ex_shiftamt;
            SHOP_SRA:  sh_res = $signed(id_ex_regb) >>> id_ex_shiftamt;
            SHOP_PASS: sh_res = id_ex_regb;
            default:   sh_res = id_ex_regb;
        endcase

        case (id_ex_mdop)
            MDOP_MFHI: wb_next = hi;
            MDOP_MFLO: wb_next = lo;
            default:   wb_next = id_ex_selalushift ? sh_res : alu_res;
        endcase
    end

    assign ex_id_stall = id_ex_valid & md_busy & md_is_use(id_ex_mdop);
    assign bubble      = ex_id_stall | flush;
    assign md_start    = id_ex_valid & ~bubble & md_is_start(id_ex_mdop);

    muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clock (clock),
        .reset (reset),
        .start (md_start),
        .op    (md_code(id_ex_mdop)),
        .a     (id_ex_rega),
        .b     (id_ex_regb),
        .busy  (md_busy),
        .hi    (hi),
        .lo    (lo)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ex_mem_readmem    <= 1'b0;
            ex_mem_writemem   <= 1'b0;
            ex_mem_selwsource <= 1'b0;
            ex_mem_writereg   <= 1'b0;
            ex_mem_regb       <= '0;
            ex_mem_wbvalue    <= '0;
            ex_mem_regdest    <= '0;
            ex_if_stall       <= 1'b0;
        end else begin
            ex_mem_readmem    <= id_ex_valid & ~bubble & id_ex_readmem;
            ex_mem_writemem   <= id_ex_valid & ~bubble & id_ex_writemem;
            // A mul/div start only writes HI/LO, never the register file.
            ex_mem_writereg   <= id_ex_valid & ~bubble & ~md_start & id_ex_writereg &
                                 (~ov | id_ex_writeov);
            ex_mem_selwsource <= id_ex_selwsource;
            ex_mem_regb       <= id_ex_regb;
            ex_mem_wbvalue    <= wb_next;
            ex_mem_regdest    <= id_ex_regdest;
            ex_if_stall       <= id_ex_valid & ~flush & ~ex_id_stall &
                                 (id_ex_readmem | id_ex_writemem);
        end
    end

endmodule

// File: tb/tb_ex_stage_md.sv
// Directed scoreboard bench for ex_stage_md: driver queues expectations, monitor compares after each edge.
module tb_ex_stage_md;
    import ex_pkg::*;

    localparam int XLEN = 32;
    localparam int REGW = 5;
    localparam int SHW  = 5;

    logic            clock = 1'b0;
    logic            reset;
    logic            flush;
    logic            id_ex_valid;
    logic [2:0]      id_ex_aluop;
    logic            id_ex_unsig, id_ex_selimregb, id_ex_selalushift;
    logic [1:0]      id_ex_shiftop;
    logic [SHW-1:0]  id_ex_shiftamt;
    logic [2:0]      id_ex_mdop;
    logic [XLEN-1:0] id_ex_rega, id_ex_regb, id_ex_imedext;
    logic            id_ex_readmem, id_ex_writemem, id_ex_selwsource, id_ex_writereg, id_ex_writeov;
    logic [REGW-1:0] id_ex_regdest;
    logic            ex_id_stall, ex_if_stall;
    logic            ex_mem_readmem, ex_mem_writemem, ex_mem_selwsource, ex_mem_writereg;
    logic [XLEN-1:0] ex_mem_regb, ex_mem_wbvalue;
    logic [REGW-1:0] ex_mem_regdest;
    logic            md_busy;

    ex_stage_md #(.XLEN(XLEN), .REGW(REGW)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .id_ex_valid(id_ex_valid), .id_ex_aluop(id_ex_aluop), .id_ex_unsig(id_ex_unsig),
        .id_ex_selimregb(id_ex_selimregb), .id_ex_selalushift(id_ex_selalushift),
        .id_ex_shiftop(id_ex_shiftop), .id_ex_shiftamt(id_ex_shiftamt), .id_ex_mdop(id_ex_mdop),
        .id_ex_rega(id_ex_rega), .id_ex_regb(id_ex_regb), .id_ex_imedext(id_ex_imedext),
        .id_ex_readmem(id_ex_readmem), .id_ex_writemem(id_ex_writemem),
        .id_ex_selwsource(id_ex_selwsource), .id_ex_writereg(id_ex_writereg),
        .id_ex_writeov(id_ex_writeov), .id_ex_regdest(id_ex_regdest),
        .ex_id_stall(ex_id_stall), .ex_if_stall(ex_if_stall),
        .ex_mem_readmem(ex_mem_readmem), .ex_mem_writemem(ex_mem_writemem),
        .ex_mem_selwsource(ex_mem_selwsource), .ex_mem_writereg(ex_mem_writereg),
        .ex_mem_regb(ex_mem_regb), .ex_mem_wbvalue(ex_mem_wbvalue),
        .ex_mem_regdest(ex_mem_regdest), .md_busy(md_busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] tag;
        logic        stall, rd, wr, wreg, ifst;
        logic        chk_wb;
        logic [31:0] wb;
        logic        chk_busy, busy;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic cmp(input logic [63:0] tag, input logic [63:0] what,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %0s %0s: got 0x%08h expected 0x%08h", tag, what, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [63:0] tag, input logic stall, input logic rd,
                                input logic wreg, input logic ifst, input logic chk_wb,
                                input logic [31:0] wb, input logic chk_busy, input logic busy);
        exp_t e;
        e.tag = tag; e.stall = stall; e.rd = rd; e.wr = 1'b0; e.wreg = wreg; e.ifst = ifst;
        e.chk_wb = chk_wb; e.wb = wb; e.chk_busy = chk_busy; e.busy = busy;
        return e;
    endfunction

    task automatic clear();
        flush = 0; id_ex_valid = 0; id_ex_aluop = ALUOP_ADD; id_ex_unsig = 0;
        id_ex_selimregb = 0; id_ex_selalushift = 0; id_ex_shiftop = SHOP_SLL; id_ex_shiftamt = '0;
        id_ex_mdop = MDOP_NONE; id_ex_rega = '0; id_ex_regb = '0; id_ex_imedext = '0;
        id_ex_readmem = 0; id_ex_writemem = 0; id_ex_selwsource = 0; id_ex_writereg = 0;
        id_ex_writeov = 0; id_ex_regdest = 5'd3;
    endtask

    task automatic t_alu(input logic [63:0] tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic unsig, input logic wov, input logic fl,
                         input logic [31:0] ewb, input logic ewreg);
        @(negedge clock);
        clear();
        id_ex_valid = 1; flush = fl; id_ex_aluop = op; id_ex_rega = a; id_ex_regb = b;
        id_ex_unsig = unsig; id_ex_writeov = wov; id_ex_writereg = 1;
        q.push_back(mk(tag, 0, 0, ewreg, 0, 1, ewb, 0, 0));
    endtask

    task automatic t_sh(input logic [63:0] tag, input logic [1:0] sop, input logic [31:0] b,
                        input logic [4:0] amt, input logic [31:0] ewb);
        @(negedge clock);
        clear();
        id_ex_valid = 1; id_ex_selalushift = 1; id_ex_shiftop = sop; id_ex_regb = b;
        id_ex_shiftamt = amt; id_ex_writereg = 1;
        q.push_back(mk(tag, 0, 0, 1, 0, 1, ewb, 0, 0));
    endtask

    task automatic t_lw(input logic [63:0] tag, input logic [31:0] a, input logic [31:0] imm,
                        input logic fl);
        @(negedge clock);
        clear();
        id_ex_valid = 1; flush = fl; id_ex_rega = a; id_ex_imedext = imm; id_ex_selimregb = 1;
        id_ex_readmem = 1; id_ex_selwsource = 1; id_ex_writereg = 1;
        q.push_back(mk(tag, 0, !fl, !fl, !fl, !fl, a + imm, 0, 0));
    endtask

    task automatic t_md(input logic [63:0] tag, input logic [2:0] mop, input logic [31:0] a,
                        input logic [31:0] b);
        @(negedge clock);
        clear();
        id_ex_valid = 1; id_ex_mdop = mop; id_ex_rega = a; id_ex_regb = b; id_ex_writereg = 1;
        q.push_back(mk(tag, 0, 0, 0, 0, 0, 32'h0, 1, 1));
    endtask

    task automatic t_nop(input logic [63:0] tag);
        @(negedge clock);
        clear();
        q.push_back(mk(tag, 0, 0, 0, 0, 0, 32'h0, 1, 1));
    endtask

    // nstall cycles held by the busy unit, then the read is accepted with the final value.
    task automatic t_read(input logic [63:0] tag, input logic [2:0] mop, input int nstall,
                          input logic [31:0] ewb);
        for (int i = 0; i <= nstall; i++) begin
            @(negedge clock);
            clear();
            id_ex_valid = 1; id_ex_mdop = mop; id_ex_writereg = 1;
            if (i < nstall)
                q.push_back(mk(tag, 1, 0, 0, 0, 0, 32'h0, (i < nstall - 1), 1));
            else
                q.push_back(mk(tag, 0, 0, 1, 0, 1, ewb, 1, 0));
        end
    endtask

    initial begin : monitor
        exp_t e;
        logic st;
        forever begin
            @(negedge clock);
            #4;
            if (q.size() > 0) begin
                e  = q.pop_front();
                st = ex_id_stall;
                @(posedge clock);
                #1;
                cmp(e.tag, "id_stall", {31'b0, st}, {31'b0, e.stall});
                cmp(e.tag, "readmem", {31'b0, ex_mem_readmem}, {31'b0, e.rd});
                cmp(e.tag, "writemem", {31'b0, ex_mem_writemem}, {31'b0, e.wr});
                cmp(e.tag, "writereg", {31'b0, ex_mem_writereg}, {31'b0, e.wreg});
                cmp(e.tag, "if_stall", {31'b0, ex_if_stall}, {31'b0, e.ifst});
                if (e.chk_wb)   cmp(e.tag, "wbvalue", ex_mem_wbvalue, e.wb);
                if (e.chk_busy) cmp(e.tag, "md_busy", {31'b0, md_busy}, {31'b0, e.busy});
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check_all_zero(input logic [63:0] tag);
        cmp(tag, "readmem", {31'b0, ex_mem_readmem}, 32'h0);
        cmp(tag, "writemem", {31'b0, ex_mem_writemem}, 32'h0);
        cmp(tag, "writereg", {31'b0, ex_mem_writereg}, 32'h0);
        cmp(tag, "selwsrc", {31'b0, ex_mem_selwsource}, 32'h0);
        cmp(tag, "if_stall", {31'b0, ex_if_stall}, 32'h0);
        cmp(tag, "wbvalue", ex_mem_wbvalue, 32'h0);
        cmp(tag, "regb", ex_mem_regb, 32'h0);
        cmp(tag, "regdest", {27'b0, ex_mem_regdest}, 32'h0);
        cmp(tag, "md_busy", {31'b0, md_busy}, 32'h0);
    endtask

    initial begin : driver
        reset = 0;
        clear();
        #12;
        check_all_zero("reset");
        @(negedge clock);
        reset = 1;

        t_alu("add_ov",  ALUOP_ADD, 32'h7FFFFFFF, 32'h1, 0, 0, 0, 32'h80000000, 0);
        t_alu("add_ovw", ALUOP_ADD, 32'h7FFFFFFF, 32'h1, 0, 1, 0, 32'h80000000, 1);
        t_alu("addu",    ALUOP_ADD, 32'h7FFFFFFF, 32'h1, 1, 0, 0, 32'h80000000, 1);
        t_alu("sub_ov",  ALUOP_SUB, 32'h80000000, 32'h1, 0, 0, 0, 32'h7FFFFFFF, 0);
        t_alu("sub",     ALUOP_SUB, 32'h5, 32'h7, 0, 0, 0, 32'hFFFFFFFE, 1);
        t_alu("and",     ALUOP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 0, 32'hF000F000, 1);
        t_alu("or",      ALUOP_OR,  32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 0, 32'hFFF0FFF0, 1);
        t_alu("xor",     ALUOP_XOR, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 0, 32'h0FF00FF0, 1);
        t_alu("nor",     ALUOP_NOR, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 0, 32'h000F000F, 1);
        t_alu("slt",     ALUOP_SLT,  32'hFFFFFFFF, 32'h1, 0, 0, 0, 32'h1, 1);
        t_alu("sltu",    ALUOP_SLTU, 32'hFFFFFFFF, 32'h1, 0, 0, 0, 32'h0, 1);
        t_sh("sll",  SHOP_SLL,  32'h1, 5'd31, 32'h80000000);
        t_sh("srl",  SHOP_SRL,  32'hFFFF0000, 5'd4, 32'h0FFFF000);
        t_sh("sra",  SHOP_SRA,  32'hFFFF0000, 5'd4, 32'hFFFFF000);
        t_sh("pass", SHOP_PASS, 32'h12345678, 5'd7, 32'h12345678);

        t_md("mult", MDOP_MULT, 32'hFFFFFFFD, 32'h5);
        t_read("mult_hi", MDOP_MFHI, 32, 32'hFFFFFFFF);
        t_read("mult_lo", MDOP_MFLO, 0, 32'hFFFFFFF1);

        t_md("divu", MDOP_DIVU, 32'd100, 32'd7);
        t_read("divu_hi", MDOP_MFHI, 32, 32'd2);
        t_read("divu_lo", MDOP_MFLO, 0, 32'd14);

        t_md("div_neg", MDOP_DIV, 32'hFFFFFFF9, 32'd2);
        t_read("divn_hi", MDOP_MFHI, 32, 32'hFFFFFFFF);
        t_read("divn_lo", MDOP_MFLO, 0, 32'hFFFFFFFD);

        t_md("div_min", MDOP_DIV, 32'h80000000, 32'hFFFFFFFF);
        t_read("divm_hi", MDOP_MFHI, 32, 32'h0);
        t_read("divm_lo", MDOP_MFLO, 0, 32'h80000000);

        t_md("div0", MDOP_DIV, 32'd5, 32'd0);
        t_alu("bsy_add", ALUOP_ADD, 32'd1, 32'd2, 0, 0, 0, 32'd3, 1);
        t_lw("bsy_lw", 32'h100, 32'h4, 0);
        t_alu("bsy_add2", ALUOP_ADD, 32'd10, 32'd20, 0, 0, 0, 32'd30, 1);
        t_lw("bsy_lw2", 32'h200, 32'h8, 0);
        t_read("div0_hi", MDOP_MFHI, 28, 32'd5);
        t_read("div0_lo", MDOP_MFLO, 0, 32'hFFFFFFFF);

        t_lw("fl_lw", 32'h300, 32'h4, 1);

        t_md("fl_mult", MDOP_MULT, 32'hFFFFFFFE, 32'h40000000);
        t_alu("fl_add", ALUOP_ADD, 32'd1, 32'd1, 0, 0, 1, 32'd2, 0);
        t_read("flm_hi", MDOP_MFHI, 31, 32'hFFFFFFFF);
        t_read("flm_lo", MDOP_MFLO, 0, 32'h80000000);

        t_md("rst_mul", MDOP_MULTU, 32'hFFFFFFFF, 32'd2);
        for (int i = 0; i < 9; i++) t_nop("rst_nop");
        t_lw("rst_lw", 32'h100, 32'h4, 0);
        @(posedge clock);
        #2;
        reset = 0;
        #1;
        check_all_zero("rst_mid");
        @(negedge clock);
        reset = 1;
        t_read("rst_hi", MDOP_MFHI, 0, 32'h0);
        t_read("rst_lo", MDOP_MFLO, 0, 32'h0);

        @(negedge clock);
        clear();
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clock);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_stage_md.md
Name: ex_stage_md

Overview:
- Parametrised execute stage for the 5-stage pipeline: XLEN-wide ALU and barrel shifter, plus an iterative multiply/divide unit with HI/LO registers.
- Sits between decode (id_ex_*) and memory (ex_mem_*).
- Registers one result per cycle and stalls decode while a multi-cycle mul/div blocks a dependent instruction.
- Adds flush/bubble insertion.

Parameters:
- XLEN, 32, datapath width (≥8, power of two)
- REGW, 5, register index width
- SHW, $clog2(XLEN), shift-amount width (derived; not overridable)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  squash the instruction currently in id_ex
- id_ex_valid  in  1  instruction present
- id_ex_aluop  in  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 nor, 110 slt, 111 sltu
- id_ex_unsig  in  1  suppress overflow detection
- id_ex_selimregb  in  1  ALU B operand = imedext
- id_ex_selalushift  in  1  wbvalue from shifter
- id_ex_shiftop  in  2  00 sll, 01 srl, 10 sra, 11 pass
- id_ex_shiftamt  in  SHW  shift amount
- id_ex_mdop  in  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mfhi, 110 mflo, 111 none
- id_ex_rega, id_ex_regb, id_ex_imedext  in  XLEN  operands
- id_ex_readmem, id_ex_writemem, id_ex_selwsource, id_ex_writereg, id_ex_writeov  in  1  control
- id_ex_regdest  in  REGW  destination
- ex_id_stall  out  1  combinational: hold id_ex this cycle
- ex_if_stall  out  1  registered: memory op issued
- ex_mem_readmem, ex_mem_writemem, ex_mem_selwsource, ex_mem_writereg  out  1
- ex_mem_regb, ex_mem_wbvalue  out  XLEN
- ex_mem_regdest  out  REGW
- md_busy  out  1  mul/div in progress

Behaviour:
- Reset is asynchronous and active-low (reset=0). It clears all ex_mem_* outputs, ex_if_stall, HI, LO, the iteration counter and md_busy to 0.
- Reset mid-operation abandons the mul/div. HI/LO read 0 afterwards.
- ALU/shift path: 1-cycle latency, registered on the rising clock edge.
  - Overflow: signed add/sub overflow when unsig=0.
  - ex_mem_writereg = writereg & (!ov | writeov) & valid.
  - slt/sltu yield 1 or 0, zero-extended.
  - sra sign-fills; shifts use the low SHW bits of shiftamt on regb.
- mfhi/mflo: wbvalue = HI or LO; otherwise same timing as an ALU op.
- Start: an accepted mult/multu/div/divu loads operands and sets counter = XLEN.
  - md_busy = (counter != 0), so md_busy is high for exactly XLEN cycles after the start edge.
  - The start instruction itself passes to ex_mem with writereg forced 0.
- Algorithm: radix-2 shift-add multiply and restoring divide on operand magnitudes.
  - Signed ops negate the results at the final step: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sign of dividend.
  - mult: {HI,LO} = 2·XLEN product. div: LO = quotient, HI = remainder.
- Divide by zero: LO = all ones, HI = dividend (unsigned or signed as given); still takes XLEN cycles.
- Signed overflow case (min / −1): LO = min, HI = 0.
- ex_id_stall = valid & md_busy & (mdop ∈ {mult, multu, div, divu, mfhi, mflo}).
  - Instructions without md usage flow unhindered while md_busy.
- Bubble rule: when ex_id_stall or flush, the next ex_mem has readmem = writemem = writereg = 0. Other fields don't-care but deterministic (pass inputs). No mul/div is started.
- Flush does not abort a mul/div already started.
- Flush and stall in the same cycle: result is a bubble.
- ex_if_stall <= valid & !flush & !ex_id_stall & (readmem | writemem).
- mfhi on the cycle md_busy falls (counter 1→0) is still stalled. It is accepted on the following cycle and sees the final HI.

Decomposition:
- Shared package ex_pkg holds the constants:
  - ALUOP_ADD..ALUOP_SLTU
  - SHOP_SLL..SHOP_PASS
  - MDOP_NONE..MDOP_MFLO
- Sub-module muldiv_iter (XLEN).
  - Ports: clock, reset, start, op[1:0], a, b, busy, hi, lo.
  - Contains the counter, partial accumulator and sign-fix logic.
- ALU and shifter stay inline combinational logic in ex_stage_md.

Test Plan:
- XLEN=32. add 0x7FFFFFFF + 0x00000001, unsig=0, writeov=0, writereg=1 -> next cycle wbvalue=0x80000000, ex_mem_writereg=0. Same with writeov=1 -> writereg=1.
- mult rega=0xFFFFFFFD (−3), regb=5, then mfhi and mflo back-to-back.
  - ex_id_stall high exactly 32 cycles.
  - mfhi returns 0xFFFFFFFF; mflo returns 0xFFFFFFF1.
- divu 100/7 -> LO=14, HI=2. div −7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- div 5/0 -> LO=0xFFFFFFFF, HI=5. While md_busy, a sequence of add/lw instructions is never stalled; lw produces ex_if_stall=1 one cycle later.
- flush asserted with an lw in id_ex -> ex_mem_readmem=0, ex_if_stall=0. flush asserted on the cycle after a mult start -> md_busy continues and HI/LO are correct.
- reset pulled low 10 cycles into a multu -> all outputs 0 immediately (asynchronously). After release, md_busy=0, mflo returns 0, no stall.
